// File: rtl/ebus_dev_responder.sv
// ebus_dev_responder: device-side EBUS responder for CONO/CONI/DATAO/DATAI.
// Decodes controller select and function, answers with a 4-phase demand/xfer handshake,
// holds a 36-bit data register plus BUSY/DONE/PIA status, and raises a PI request.
// Data buses use PDP-10 bit numbering [0:35], bit 0 being the MSB.
// Optional feature macro: EBUS_PARITY_EN (adds odd-parity generation/checking).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ebus_cs, ebus_func    device select (7 bits), function (0 CONI,1 CONO,2 DATAI,3 DATAO)
//   ebus_demand           controller demand, held until xfer seen
//   ebus_data_in          write data from the bus (CONO/DATAO)
//   ebus_data_out/_oe     read data and its drive enable (CONI/DATAI)
//   ebus_xfer             registered transfer acknowledge
//   dev_done              one-clock pulse from device core, sets DONE
//   pi_req, pi_level      interrupt request and its PIA level
//   ebus_par_in/_out, par_err   parity ports (EBUS_PARITY_EN only)
module ebus_dev_responder #(
  parameter logic [6:0]  DEV_CODE   = 7'o100,
  parameter int unsigned RESP_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ebus_cs,
  input  logic [2:0]  ebus_func,
  input  logic        ebus_demand,
  input  logic [0:35] ebus_data_in,
  output logic [0:35] ebus_data_out,
  output logic        ebus_data_oe,
  output logic        ebus_xfer,
  input  logic        dev_done,
  output logic        pi_req,
  output logic [2:0]  pi_level
`ifdef EBUS_PARITY_EN
  ,
  input  logic        ebus_par_in,
  output logic        ebus_par_out,
  output logic        par_err
`endif
);

  localparam logic [3:0] CntLoad = 4'(RESP_DELAY - 1);

  localparam logic [1:0] FnConi  = 2'd0;
  localparam logic [1:0] FnCono  = 2'd1;
  localparam logic [1:0] FnDatai = 2'd2;
  localparam logic [1:0] FnDatao = 2'd3;

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StRel} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  func_q, func_d;
  logic [0:35] data_q, data_d;
  logic [0:35] dout_q, dout_d;
  logic [2:0]  pia_q, pia_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        xfer_q, xfer_d;
  logic        oe_q, oe_d;
  logic        enter_xfer;
  logic        coni_par;
  logic [0:35] coni_word;

`ifdef EBUS_PARITY_EN
  logic par_err_q, par_err_d;
  assign coni_par     = par_err_q;
  assign par_err      = par_err_q;
  // Odd parity over data_out + par_out; only meaningful while driving.
  assign ebus_par_out = oe_q & ~(^dout_q);
`else
  assign coni_par = 1'b0;
`endif

  assign coni_word     = {30'd0, busy_q, done_q, coni_par, pia_q};
  assign ebus_data_out = dout_q;
  assign ebus_data_oe  = oe_q;
  assign ebus_xfer     = xfer_q;
  assign pi_req        = done_q & (pia_q != 3'd0);
  assign pi_level      = pi_req ? pia_q : 3'd0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    func_d     = func_q;
    data_d     = data_q;
    dout_d     = dout_q;
    pia_d      = pia_q;
    busy_d     = busy_q;
    done_d     = done_q;
    xfer_d     = xfer_q;
    oe_d       = oe_q;
    enter_xfer = 1'b0;
`ifdef EBUS_PARITY_EN
    par_err_d  = par_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        // cs/func are latched here and ignored for the rest of the transaction.
        if (ebus_demand && (ebus_cs == DEV_CODE) && !ebus_func[2]) begin
          state_d = StWait;
          func_d  = ebus_func[1:0];
          cnt_d   = CntLoad;
        end
      end
      StWait: begin
        if (!ebus_demand) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d    = StXfer;
          enter_xfer = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StXfer: begin
        if (!ebus_demand) begin
          state_d = StRel;
          xfer_d  = 1'b0;
          oe_d    = 1'b0;
          dout_d  = '0;
        end
      end
      StRel: begin
        // Demand must be seen low for one more clock before reselect is allowed.
        if (!ebus_demand) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_xfer) begin
      xfer_d = 1'b1;
      // Read data is captured from pre-update registers on the entry edge.
      unique case (func_q)
        FnConi: begin
          oe_d   = 1'b1;
          dout_d = coni_word;
        end
        FnCono: begin
          pia_d = ebus_data_in[33:35];
          if (ebus_data_in[30]) busy_d = 1'b1;
          if (ebus_data_in[29]) busy_d = 1'b0;
          if (ebus_data_in[31]) done_d = 1'b0;
`ifdef EBUS_PARITY_EN
          if (ebus_data_in[32]) par_err_d = 1'b0;
`endif
        end
        FnDatai: begin
          oe_d   = 1'b1;
          dout_d = data_q;
          done_d = 1'b0;
        end
        FnDatao: begin
          data_d = ebus_data_in;
          done_d = 1'b0;
        end
      endcase
`ifdef EBUS_PARITY_EN
      // Write functions: even total parity flags an error; the data still loads.
      if (func_q[0] && !(^{ebus_data_in, ebus_par_in})) par_err_d = 1'b1;
`endif
    end

    // A completion pulse beats any simultaneous DONE clear.
    if (dev_done) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      func_q    <= 2'd0;
      data_q    <= '0;
      dout_q    <= '0;
      pia_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      xfer_q    <= 1'b0;
      oe_q      <= 1'b0;
`ifdef EBUS_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      data_q    <= data_d;
      dout_q    <= dout_d;
      pia_q     <= pia_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      xfer_q    <= xfer_d;
      oe_q      <= oe_d;
`ifdef EBUS_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ebus_dev_responder.sv
// Self-checking bench for ebus_dev_responder: directed steps plus randomized operations,
// compared against a status/data model kept as plain integers.
module tb_ebus_dev_responder;
  localparam int unsigned RD  = 2;
  localparam logic [6:0]  DEV = 7'o100;
`ifdef EBUS_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  ebus_cs = '0;
  logic [2:0]  ebus_func = '0;
  logic        ebus_demand = 1'b0;
  logic [35:0] ebus_data_in = '0;
  logic [35:0] ebus_data_out;
  logic        ebus_data_oe;
  logic        xfer;
  logic        dev_done = 1'b0;
  logic        pi_req;
  logic [2:0]  pi_level;
`ifdef EBUS_PARITY_EN
  logic        ebus_par_in = 1'b0;
  logic        ebus_par_out;
  logic        par_err;
`endif

  int checks = 0;
  int failures = 0;

  // Model state
  logic [35:0] m_data;
  int          m_pia;
  bit          m_busy, m_done, m_par;

  always #5 clk = ~clk;

  ebus_dev_responder #(
    .DEV_CODE  (DEV),
    .RESP_DELAY(RD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ebus_cs      (ebus_cs),
    .ebus_func    (ebus_func),
    .ebus_demand  (ebus_demand),
    .ebus_data_in (ebus_data_in),
    .ebus_data_out(ebus_data_out),
    .ebus_data_oe (ebus_data_oe),
    .ebus_xfer    (xfer),
    .dev_done     (dev_done),
    .pi_req       (pi_req),
    .pi_level     (pi_level)
`ifdef EBUS_PARITY_EN
    ,
    .ebus_par_in  (ebus_par_in),
    .ebus_par_out (ebus_par_out),
    .par_err      (par_err)
`endif
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Bit k in PDP-10 numbering (bit 0 = MSB).
  function automatic bit pbit(input logic [35:0] d, input int k);
    return d[35-k];
  endfunction

  function automatic logic [35:0] coni_model();
    return 36'((m_busy ? 32 : 0) + (m_done ? 16 : 0) + (m_par ? 8 : 0) + m_pia);
  endfunction

  task automatic model_reset();
    m_data = '0; m_pia = 0; m_busy = 0; m_done = 0; m_par = 0;
  endtask

  task automatic check_pi();
    bit exp_req;
    exp_req = m_done && (m_pia != 0);
    check1("pi_req", pi_req, exp_req);
    check("pi_level", 36'(pi_level), exp_req ? 36'(m_pia) : 36'd0);
  endtask

  // Full transaction with latency, data, release and PI checks.
  task automatic op(input logic [2:0] fn, input logic [35:0] wd, input bit pulse,
                    input bit bad_par);
    logic [35:0] exp_rd;
    bit          rd_fn;
    rd_fn  = (fn == 3'd0) || (fn == 3'd2);
    exp_rd = (fn == 3'd0) ? coni_model() : ((fn == 3'd2) ? m_data : 36'd0);
    @(posedge clk); #1;
    ebus_cs = DEV; ebus_func = fn; ebus_data_in = wd; ebus_demand = 1'b1;
`ifdef EBUS_PARITY_EN
    ebus_par_in = ~(^wd) ^ bad_par;
`endif
    for (int e = 1; e <= int'(RD) + 1; e++) begin
      if (pulse && e == int'(RD) + 1) dev_done = 1'b1;
      @(posedge clk); #1;
      dev_done = 1'b0;
      if (e == 1) begin
        // Selection is latched; later changes must not matter.
        ebus_cs   = 7'($urandom);
        ebus_func = 3'($urandom);
      end
      if (e == int'(RD)) begin
        check1("xfer_early", xfer, 1'b0);
        check1("oe_early", ebus_data_oe, 1'b0);
      end
    end
    check1("xfer_latency", xfer, 1'b1);
    check1("oe_in_xfer", ebus_data_oe, rd_fn);
    check("data_out", ebus_data_out, exp_rd);
`ifdef EBUS_PARITY_EN
    check1("par_out", ebus_par_out, rd_fn ? ~(^exp_rd) : 1'b0);
`endif
    case (fn)
      3'd1: begin
        m_pia = int'(wd[2:0]);
        if (pbit(wd, 30)) m_busy = 1;
        if (pbit(wd, 29)) m_busy = 0;
        if (pbit(wd, 31)) m_done = 0;
        if (ParEn && pbit(wd, 32)) m_par = 0;
      end
      3'd2: m_done = 0;
      3'd3: begin m_data = wd; m_done = 0; end
      default: ;
    endcase
    if (ParEn && bad_par && (fn == 3'd1 || fn == 3'd3)) m_par = 1;
    if (pulse) m_done = 1;
    @(posedge clk); #1;
    check("data_out_stable", ebus_data_out, exp_rd);
    ebus_demand = 1'b0;
    @(posedge clk); #1;
    check1("xfer_release", xfer, 1'b0);
    check1("oe_release", ebus_data_oe, 1'b0);
    check("data_out_release", ebus_data_out, 36'd0);
    check_pi();
    @(posedge clk); #1;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; dev_done = 1'b1;
    @(posedge clk); #1; dev_done = 1'b0;
    m_done = 1;
    check_pi();
  endtask

  task automatic no_resp(input logic [6:0] cs, input logic [2:0] fn, input string tag);
    bit any;
    any = 0;
    @(posedge clk); #1;
    ebus_cs = cs; ebus_func = fn; ebus_data_in = 36'o777; ebus_demand = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (xfer !== 1'b0 || ebus_data_oe !== 1'b0) any = 1;
    end
    check1(tag, any, 1'b0);
    ebus_demand = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    logic [35:0] wd;
    logic [2:0]  fn;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst_xfer", xfer, 1'b0);
    check1("rst_oe", ebus_data_oe, 1'b0);
    check("rst_data_out", ebus_data_out, 36'd0);
    check1("rst_pi_req", pi_req, 1'b0);
    check("rst_pi_level", 36'(pi_level), 36'd0);
    rst_n = 1'b1;
    op(3'd0, 36'd0, 0, 0);

    // CONO: PIA=5, BUSY set; CONI readback
    op(3'd1, 36'o000000000045, 0, 0);
    check("cono_model_coni", coni_model(), 36'o000000000045);
    op(3'd0, 36'd0, 0, 0);

    // DATAO / DATAI
    op(3'd3, 36'o123456701234, 0, 0);
    op(3'd2, 36'd0, 0, 0);

    // Interrupt: PIA=3 then device completion
    op(3'd1, 36'o000000000003, 0, 0);
    pulse_done();
    check1("irq_req", pi_req, 1'b1);
    check("irq_level", 36'(pi_level), 36'd3);
    // CONO clearing DONE on the same clock as dev_done: DONE stays set
    op(3'd1, 36'o000000000023, 1, 0);
    check1("done_set_wins", pi_req, 1'b1);

    // BUSY set and clear together: clear wins
    op(3'd1, 36'o000000000043, 0, 0);
    op(3'd1, 36'o000000000143, 0, 0);
    op(3'd0, 36'd0, 0, 0);

    // Reset asserted in the middle of a transfer
    @(posedge clk); #1;
    ebus_cs = DEV; ebus_func = 3'd0; ebus_demand = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (xfer === 1'b1);
    end
    check1("midrst_xfer_seen", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst_xfer", xfer, 1'b0);
    check1("midrst_oe", ebus_data_oe, 1'b0);
    check1("midrst_pi_req", pi_req, 1'b0);
    check("midrst_data_out", ebus_data_out, 36'd0);
    ebus_demand = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(3'd0, 36'd0, 0, 0);

    // Not selected / ignored function
    no_resp(7'o101, 3'd1, "noresp_cs101");
    no_resp(DEV, 3'd5, "noresp_func5");

    // Demand dropped during WAIT must not load DATA
    op(3'd3, {4'($urandom), 32'($urandom)}, 0, 0);
    @(posedge clk); #1;
    ebus_cs = DEV; ebus_func = 3'd3; ebus_data_in = {4'($urandom), 32'($urandom)};
    ebus_demand = 1'b1;
    @(posedge clk); #1;
    ebus_demand = 1'b0;
    seen = 0;
    repeat (RD + 3) begin
      @(posedge clk); #1;
      if (xfer !== 1'b0) seen = 1;
    end
    check1("wait_drop_no_xfer", seen, 1'b0);
    op(3'd2, 36'd0, 0, 0);

    // Parity error path (only when built with the parity ports)
    if (ParEn) begin
      op(3'd3, 36'o1, 0, 1);
      op(3'd0, 36'd0, 0, 0);
      op(3'd1, 36'o000000000010, 0, 0);
      op(3'd0, 36'd0, 0, 0);
    end

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      fn = 3'($urandom_range(0, 3));
      wd = {4'($urandom), 32'($urandom)};
      op(fn, wd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) pulse_done();
    end
    op(3'd0, 36'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
